// File: rtl/mba_share_arbiter_if.sv
// Handshake and multiplier-bus bundle between the requesters, the shared
// multiplier and mba_share_arbiter.
interface mba_share_arbiter_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [15:0]       mul_p;
    logic              resp_valid;
    logic              resp_ready;
    logic [ID_W-1:0]   resp_id;
    logic [15:0]       resp_p;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_p, resp_ready,
        output req_ready, mul_a, mul_b, resp_valid, resp_id, resp_p, busy
    );

    modport master (
        output req_valid, req_a, req_b, mul_p, resp_ready,
        input  req_ready, mul_a, mul_b, resp_valid, resp_id, resp_p, busy
    );
endinterface

// File: rtl/mba_share_arbiter.sv
// Round-robin sequencer sharing one external 8x8 multiplier between NREQ
// requesters: accept, wait MUL_LAT cycles, return product with requester ID.
module mba_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    mba_share_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t          r_state, w_state_nxt;
    logic [ID_W-1:0] r_rr_ptr;
    logic [ID_W-1:0] r_gnt_id;
    logic [3:0]      r_wait_cnt;
    logic [7:0]      r_mul_a, r_mul_b;
    logic            r_resp_valid;
    logic [ID_W-1:0] r_resp_id;
    logic [15:0]     r_resp_p;

    logic            w_gnt_any;
    logic [ID_W-1:0] w_gnt_id;
    logic [NREQ-1:0] w_gnt_oh;

    // First pending requester at or after rr_ptr; ID_W-bit sum wraps mod NREQ.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_gnt_oh  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_gnt_any && bus.req_valid[r_rr_ptr + ID_W'(k)]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = r_rr_ptr + ID_W'(k);
            end
        end
        w_gnt_oh[w_gnt_id] = w_gnt_any;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_any)            w_state_nxt = WAIT;
            WAIT:    if (r_wait_cnt == 4'd1)   w_state_nxt = RESP;
            RESP:    if (bus.resp_ready)       w_state_nxt = IDLE;
            default:                           w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rr_ptr     <= '0;
            r_gnt_id     <= '0;
            r_wait_cnt   <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_p     <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_gnt_any) begin
                    r_mul_a    <= bus.req_a[8*w_gnt_id +: 8];
                    r_mul_b    <= bus.req_b[8*w_gnt_id +: 8];
                    r_gnt_id   <= w_gnt_id;
                    r_wait_cnt <= 4'(MUL_LAT);
                end
                WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt == 4'd1) begin
                        r_resp_p     <= bus.mul_p;
                        r_resp_id    <= r_gnt_id;
                        r_resp_valid <= 1'b1;
                    end
                end
                RESP: if (bus.resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_rr_ptr     <= r_gnt_id + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Gated by reset so no grant is advertised while reset is held.
    assign bus.req_ready  = (r_state == IDLE && reset_n) ? w_gnt_oh : '0;
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_p     = r_resp_p;
    assign bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_mba_share_arbiter.sv
// Bench for mba_share_arbiter with a behavioural MUL_LAT=2 signed multiplier
// and a response scoreboard.
module tb_mba_share_arbiter;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    mba_share_arbiter_if #(.NREQ(4), .ID_W(2)) bus ();

    mba_share_arbiter #(.NREQ(4), .ID_W(2), .MUL_LAT(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Product becomes valid one edge after the operands change, so it is
    // stable MUL_LAT=2 cycles after a change.
    logic signed [15:0] r_p;
    always @(posedge clock) r_p <= $signed(bus.mul_a) * $signed(bus.mul_b);
    assign bus.mul_p = r_p;

    typedef struct {
        logic [1:0]  id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  rdy;
        logic [15:0] p;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] p;
    } exp_t;

    vec_t vt [5];
    exp_t sb [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        bus.req_a[8*i +: 8] = a;
        bus.req_b[8*i +: 8] = b;
    endtask

    always @(negedge clock) begin
        if (reset_n && bus.resp_valid && bus.resp_ready) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", {bus.resp_id, bus.resp_p}, 64'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id", bus.resp_id, e.id);
                chk("resp_p", bus.resp_p, e.p);
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;

        vt[0] = '{2'd1, 8'd7,   8'd6,   4'b0010, 16'h002A};
        vt[1] = '{2'd0, 8'hFD,  8'd5,   4'b0001, 16'hFFF1};
        vt[2] = '{2'd0, 8'h80,  8'h80,  4'b0001, 16'h4000};
        vt[3] = '{2'd2, 8'd100, 8'hFE,  4'b0100, 16'hFF38};
        vt[4] = '{2'd3, 8'hFF,  8'd127, 4'b1000, 16'hFF81};

        // Reset held over 3 edges with random inputs
        for (int i = 0; i < 3; i++) begin
            step();
            bus.req_valid  = 4'($urandom);
            bus.req_a      = $urandom;
            bus.req_b      = $urandom;
            bus.resp_ready = 1'($urandom);
            #1;
            chk("reset_outs", {bus.req_ready, bus.mul_a, bus.mul_b, bus.resp_valid,
                               bus.resp_id, bus.resp_p, bus.busy}, 64'd0);
        end
        step();
        bus.req_valid  = '0;
        bus.resp_ready = 1'b0;
        reset_n        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_after_reset", {bus.busy, bus.req_ready, bus.resp_valid}, 64'd0);
        end

        // Table vectors: single requester, accept-to-response timing
        for (int i = 0; i < 5; i++) begin
            step();
            set_req(int'(vt[i].id), vt[i].a, vt[i].b);
            bus.req_valid  = 4'b0001 << vt[i].id;
            bus.resp_ready = 1'b1;
            #1;
            chk("vec_ready", bus.req_ready, vt[i].rdy);
            sb.push_back('{vt[i].id, vt[i].p});
            step();
            bus.req_valid = '0;
            #1;
            chk("vec_mul_ab", {bus.mul_a, bus.mul_b}, {vt[i].a, vt[i].b});
            chk("vec_busy", {bus.busy, bus.req_ready}, {1'b1, 4'b0000});
            step();
            chk("vec_early", bus.resp_valid, 1'b0);
            step();
            chk("vec_resp_valid", bus.resp_valid, 1'b1);
            step();
            chk("vec_idle", bus.busy, 1'b0);
        end

        // Round robin with every requester pending (rr_ptr is 0 here)
        step();
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'd2);
        bus.req_valid  = 4'hF;
        bus.resp_ready = 1'b1;
        sb.push_back('{2'd0, 16'd2});
        sb.push_back('{2'd1, 16'd4});
        sb.push_back('{2'd2, 16'd6});
        sb.push_back('{2'd3, 16'd8});
        sb.push_back('{2'd0, 16'd2});
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant", bus.req_ready, 4'b0001 << (k % 4));
            if (k < 4) repeat (4) step();
        end
        step();
        bus.req_valid = '0;
        repeat (3) step();

        // Backpressure with requester 2 waiting (rr_ptr is 1 here)
        step();
        set_req(1, 8'd9, 8'd3);
        set_req(2, 8'hFB, 8'd4);
        bus.req_valid  = 4'b0110;
        bus.resp_ready = 1'b0;
        #1;
        chk("bp_grant", bus.req_ready, 4'b0010);
        sb.push_back('{2'd1, 16'h001B});
        sb.push_back('{2'd2, 16'hFFEC});
        step();
        bus.req_valid = 4'b0100;
        step();
        step();
        for (int j = 0; j < 5; j++) begin
            chk("bp_hold", {bus.resp_valid, bus.resp_id, bus.resp_p, bus.req_ready, bus.mul_a},
                {1'b1, 2'd1, 16'h001B, 4'b0000, 8'd9});
            step();
        end
        bus.resp_ready = 1'b1;
        step();
        chk("bp_next_grant", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = '0;
        step();
        step();
        chk("bp_resp2_valid", bus.resp_valid, 1'b1);
        step();

        // Reset during WAIT abandons the op and clears rr_ptr (was 3)
        step();
        set_req(3, 8'd1, 8'd1);
        bus.req_valid = 4'b1000;
        #1;
        chk("mid_grant", bus.req_ready, 4'b1000);
        step();
        bus.req_valid = '0;
        reset_n       = 1'b0;
        step();
        reset_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("mid_no_resp", {bus.resp_valid, bus.busy}, 64'd0);
        end
        for (int i = 0; i < 4; i++) set_req(i, 8'(i + 1), 8'd3);
        bus.req_valid = 4'hF;
        #1;
        chk("mid_rr_reset", bus.req_ready, 4'b0001);
        sb.push_back('{2'd0, 16'd3});
        step();
        bus.req_valid = '0;
        step();
        step();
        chk("mid_resp_valid", bus.resp_valid, 1'b1);
        step();
        step();
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mba_share_arbiter.md
Name: mba_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 8x8 radix-4 Booth multiplier between NREQ requesters.
- Accepts one operand pair at a time over a valid/ready handshake and drives the multiplier's operand inputs.
- Waits a fixed MUL_LAT cycles for the product, then returns it with the requester ID over a valid/ready response channel.
- Sits between client blocks and the multiplier instance; contains no arithmetic of its own.

Parameters:
- NREQ, 4, number of requesters; power of 2, range 2..8.
- ID_W, 2, response ID width; must equal log2(NREQ).
- MUL_LAT, 2, clock cycles from a mul_a/mul_b change to a valid mul_p; range 1..15.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit i: requester i has an operand pair pending.
- req_a  in  8*NREQ  requester i multiplicand at [8i+7:8i], signed two's complement.
- req_b  in  8*NREQ  requester i multiplier at [8i+7:8i], signed two's complement.
- req_ready  out  NREQ  one-hot grant/accept; transfer on req_valid[i] & req_ready[i].
- mul_a  out  8  multiplicand to the shared multiplier (registered).
- mul_b  out  8  multiplier operand to the shared multiplier (registered).
- mul_p  in  16  product from the shared multiplier.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  ID_W  index of the requester that owns resp_p.
- resp_p  out  16  captured product.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, rr_ptr=0, wait_cnt=0;
  - mul_a=0, mul_b=0;
  - resp_valid=0, resp_id=0, resp_p=0, busy=0, req_ready=0.
- Reset mid-operation abandons the in-flight op; no response is ever produced for it.
- Grant is combinational: the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
- req_ready = grant one-hot, only when state==IDLE; all zero in every other state.
- A requester holds req_valid and its operands stable until accepted. Dropping req_valid before accept is legal; the arbiter re-evaluates every cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid, on that edge:
  - mul_a/mul_b <= the granted requester's operands;
  - gnt_id <= granted index;
  - wait_cnt <= MUL_LAT;
  - go to WAIT.
  - Otherwise stay in IDLE.
- WAIT: wait_cnt decrements each cycle. On the edge where wait_cnt==1:
  - resp_p <= mul_p, resp_id <= gnt_id, resp_valid <= 1;
  - go to RESP.
- RESP: hold resp_valid, resp_id and resp_p stable until resp_ready=1. On that handshake edge:
  - resp_valid <= 0;
  - rr_ptr <= (gnt_id+1) mod NREQ;
  - go to IDLE.
- mul_a/mul_b change only on an IDLE accept; they hold their value through WAIT, RESP and IDLE.
- Timing:
  - accept edge to resp_valid high = MUL_LAT+1 edges;
  - with resp_ready tied high, minimum op period = MUL_LAT+2 cycles.
- rr_ptr advances only on a completed response, so the last-served requester gets lowest priority. No starvation: every asserted requester is served within NREQ ops.
- Simultaneous events:
  - req_valid changes during WAIT/RESP have no effect;
  - resp_ready while resp_valid=0 is ignored;
  - all req_valid asserted with rr_ptr=k grants k.
- Wrap-around: rr_ptr=NREQ-1 after service goes to 0; the search wraps modulo NREQ.

Test Plan:
- Reset values: hold reset_n=0 over 3 edges with random inputs -> every output 0, busy=0; release, no req -> stays idle.
- Single op (MUL_LAT=2 behavioural signed multiplier model): req 1 with a=7, b=6 -> req_ready=0010 in the accept cycle; mul_a=7, mul_b=6; resp_valid exactly 3 edges later with resp_id=1, resp_p=0x002A.
- Signed operands: req 0 with a=-3 (0xFD), b=5 -> resp_p=0xFFF1, resp_id=0. Also a=-128, b=-128 -> resp_p=0x4000.
- Round-robin: all four req_valid held high, operands a=i+1, b=2, resp_ready=1 -> grant order 0,1,2,3,0; resp_p = 2,4,6,8,2; each op 4 cycles apart.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid with req 2 also pending -> resp_p/resp_id stable, req_ready stays 0, mul_a unchanged; after the handshake, req 2 is granted in the next IDLE cycle.
- Reset mid-op: assert reset_n=0 during WAIT -> no resp_valid afterwards; rr_ptr=0, so with all requesters pending the first grant goes to 0.
